// File: rtl/keypad_conditioner.sv
// Purpose: synchronize, debounce and edge-detect the raw enter button; capture the digit alongside each accepted press.
// Latency: enter_pulse rises SYNC_STAGES+DEBOUNCE_CYCLES cycles after a clean raw press edge.
// Backpressure: none; one pulse per debounced press, no auto-repeat.
module keypad_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_raw,
    input  logic [3:0] digit_raw,
    output logic       enter_pulse,
    output logic [3:0] digit_out,
    output logic       key_held,
    output logic [7:0] press_count
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        FIRE,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0]      enter_sync;
    logic [SYNC_STAGES-1:0][3:0] digit_sync;
    logic                        enter_s;
    logic [3:0]                  digit_s;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_sync <= '0;
            digit_sync <= '0;
        end else begin
            enter_sync <= {enter_sync[SYNC_STAGES-2:0], enter_raw};
            digit_sync <= {digit_sync[SYNC_STAGES-2:0], digit_raw};
        end
    end

    assign enter_s = enter_sync[SYNC_STAGES-1];
    assign digit_s = digit_sync[SYNC_STAGES-1];

    // The first sample that leaves IDLE/HELD already counts toward the stable run, hence cnt=1 on entry.
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (enter_s) begin
                    next_state = PRESS_WAIT;
                    cnt_nxt    = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!enter_s) begin
                    next_state = IDLE;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = FIRE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            FIRE: begin
                next_state = HELD;
                cnt_nxt    = '0;
            end
            HELD: begin
                if (!enter_s) begin
                    next_state = RELEASE_WAIT;
                    cnt_nxt    = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (enter_s) begin
                    next_state = HELD;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe, glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_pulse <= 1'b0;
            key_held    <= 1'b0;
            digit_out   <= '0;
            press_count <= '0;
        end else begin
            enter_pulse <= (next_state == FIRE);
            key_held    <= (next_state == FIRE) || (next_state == HELD) || (next_state == RELEASE_WAIT);
            if (next_state == FIRE && state != FIRE) begin
                digit_out   <= digit_s;
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Self-checking bench for keypad_conditioner: directed press/bounce/reset scenarios plus random bursts,
// compared every cycle against a run-length model of the debounced key.
module tb_keypad_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enter_raw = 1'b0;
    logic [3:0] digit_raw = 4'h0;
    logic       enter_pulse;
    logic [3:0] digit_out;
    logic       key_held;
    logic [7:0] press_count;

    keypad_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .enter_raw   (enter_raw),
        .digit_raw   (digit_raw),
        .enter_pulse (enter_pulse),
        .digit_out   (digit_out),
        .key_held    (key_held),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model: the key is either released or held; it flips after DB consecutive
    // synchronized samples disagreeing with its current level. The sample right after a firing is ignored.
    logic       m_eh [SYNC];
    logic [3:0] m_dh [SYNC];
    int         m_run;
    bit         m_held, m_skip, m_pulse;
    logic [3:0] m_digit;
    logic [7:0] m_count;

    int cyc = 0;
    int dut_pulses = 0;
    int last_pulse_cyc = -1;
    int last_fall_cyc = -1;
    bit held_prev = 0;

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) begin
            m_eh[i] = 1'b0;
            m_dh[i] = 4'h0;
        end
        m_run = 0; m_held = 0; m_skip = 0; m_pulse = 0;
        m_digit = 4'h0; m_count = 8'h0;
        held_prev = 0;
    endtask

    task automatic model_edge(input logic e, input logic [3:0] d);
        logic       s;
        logic [3:0] ds;
        s  = m_eh[SYNC-1];
        ds = m_dh[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) begin
            m_eh[i] = m_eh[i-1];
            m_dh[i] = m_dh[i-1];
        end
        m_eh[0] = e;
        m_dh[0] = d;
        m_pulse = 0;
        if (m_skip) begin
            m_skip = 0;
            m_run  = 0;
        end else if (!m_held) begin
            m_run = s ? m_run + 1 : 0;
            if (m_run == DB) begin
                m_pulse = 1; m_held = 1; m_skip = 1; m_run = 0;
                m_count = m_count + 8'd1;
                m_digit = ds;
            end
        end else begin
            m_run = !s ? m_run + 1 : 0;
            if (m_run == DB) begin
                m_held = 0; m_run = 0;
            end
        end
    endtask

    task automatic tick(input logic e, input logic [3:0] d);
        enter_raw = e;
        digit_raw = d;
        @(posedge clk);
        cyc++;
        model_edge(e, d);
        @(negedge clk);
        chk("cycle", {18'd0, enter_pulse, key_held, digit_out, press_count},
                     {18'd0, m_pulse, m_held, m_digit, m_count});
        if (enter_pulse) begin
            dut_pulses++;
            last_pulse_cyc = cyc;
        end
        if (held_prev && !key_held) last_fall_cyc = cyc;
        held_prev = key_held;
    endtask

    task automatic apply_reset(input logic e_after, input logic [3:0] d_after);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_out", {18'd0, enter_pulse, key_held, digit_out, press_count}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        enter_raw = e_after;
        digit_raw = d_after;
    endtask

    int c, p0;

    initial begin
        model_reset();
        apply_reset(1'b0, 4'h0);

        // Clean press with digit 9
        repeat (3) tick(1'b0, 4'h9);
        c = cyc; p0 = dut_pulses;
        repeat (40) tick(1'b1, 4'h9);
        chk("clean_pulses", dut_pulses - p0, 1);
        chk("clean_latency", last_pulse_cyc - c, 18);
        chk("clean_digit", digit_out, 4'h9);
        chk("clean_held", key_held, 1);
        chk("clean_count", press_count, 1);
        repeat (24) tick(1'b0, 4'h9);
        chk("clean_released", key_held, 0);

        // Reset in the middle of a press debounce, released with the button still down
        repeat (8) tick(1'b1, 4'h5);
        apply_reset(1'b1, 4'h5);
        c = cyc; p0 = dut_pulses;
        repeat (17) tick(1'b1, 4'h5);
        chk("rst_no_early", dut_pulses - p0, 0);
        repeat (13) tick(1'b1, 4'h5);
        chk("rst_pulses", dut_pulses - p0, 1);
        chk("rst_latency", last_pulse_cyc - c, 18);
        repeat (24) tick(1'b0, 4'h5);

        // Press bounce: toggles every 3 cycles, then settles high
        p0 = dut_pulses;
        for (int i = 0; i < 30; i++) tick(((i / 3) % 2) == 0, 4'h2);
        c = cyc;
        repeat (40) tick(1'b1, 4'h2);
        chk("pbounce_pulses", dut_pulses - p0, 1);
        chk("pbounce_latency", last_pulse_cyc - c, 18);

        // Release bounce
        p0 = dut_pulses;
        for (int i = 0; i < 10; i++) tick((i % 2) == 1, 4'h2);
        c = cyc;
        repeat (30) tick(1'b0, 4'h2);
        chk("rbounce_pulses", dut_pulses - p0, 0);
        chk("rbounce_fall", last_fall_cyc - c, 18);
        chk("rbounce_held", key_held, 0);

        // Digit isolation while held and idle
        repeat (24) tick(1'b1, 4'h3);
        repeat (10) tick(1'b1, 4'h7);
        chk("iso_held_digit", digit_out, 4'h3);
        repeat (24) tick(1'b0, 4'h7);
        chk("iso_idle_digit", digit_out, 4'h3);
        repeat (24) tick(1'b1, 4'h7);
        chk("iso_next_digit", digit_out, 4'h7);
        repeat (24) tick(1'b0, 4'h7);

        // Random bursts with random digits and run lengths
        for (int n = 0; n < 60; n++) begin
            logic e;
            int   len;
            e   = n[0];
            len = $urandom_range(1, 26);
            for (int k = 0; k < len; k++) tick(e, 4'($urandom));
        end
        repeat (40) tick(1'b0, 4'h0);

        // Wrap: 256 clean presses from a fresh count
        apply_reset(1'b0, 4'h0);
        p0 = dut_pulses;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] dg;
            dg = 4'(i);
            repeat (24) tick(1'b1, dg);
            repeat (24) tick(1'b0, dg);
        end
        chk("wrap_pulses", dut_pulses - p0, 256);
        chk("wrap_count", press_count, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
